// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage registers between IF/ID/EX/MEM/WB.
// Boundary widths and NOP payloads live here so every stage instantiates the same register block.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL2 = 2'd2
    } state_t;

    // Flags registered alongside the state so no output is decoded combinationally
    typedef struct packed {
        logic       valid;
        logic       ready;
        logic [1:0] occ;
    } flags_t;

    localparam int unsigned IF_ID_W  = 64;
    localparam int unsigned ID_EX_W  = 184;
    localparam int unsigned EX_MEM_W = 150;
    localparam int unsigned MEM_WB_W = 142;

    localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = '0;
    localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = '0;
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;
    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = '0;

    function automatic flags_t flags_of(input state_t s);
        flags_t f;
        f.valid = (s != ST_EMPTY);
        f.ready = (s != ST_FULL2);
        case (s)
            ST_ONE:   f.occ = 2'd1;
            ST_FULL2: f.occ = 2'd2;
            default:  f.occ = 2'd0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and optional two-entry skid buffer.
// Empty entries always hold NOP_VALUE so write enables in the payload stay cleared on bubbles.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = MEM_WB_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter bit                SKID      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    state_t            state;
    state_t            state_n;
    flags_t            flags;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_n;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_n;
    logic              in_fire;
    logic              out_fire;

    // Without the skid entry, ready must see downstream in the same cycle
    assign in_ready  = SKID ? flags.ready : (~flags.valid | out_ready);
    assign out_valid = flags.valid;
    assign occupancy = flags.occ;
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = flags.valid & out_ready;

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_n = ST_ONE;
                    main_n  = in_data;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_n = in_data;
                end else if (in_fire && SKID) begin
                    state_n = ST_FULL2;
                    skid_n  = in_data;
                end else if (out_fire) begin
                    state_n = ST_EMPTY;
                    main_n  = NOP_VALUE;
                end
            end
            ST_FULL2: begin
                if (out_fire) begin
                    state_n = ST_ONE;
                    main_n  = skid_q;
                    skid_n  = NOP_VALUE;
                end
            end
            default: begin
                state_n = ST_EMPTY;
                main_n  = NOP_VALUE;
                skid_n  = NOP_VALUE;
            end
        endcase
    end

    // Flush shares the reset path; any same-cycle handshake is discarded
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state  <= ST_EMPTY;
            flags  <= flags_of(ST_EMPTY);
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else begin
            state  <= state_n;
            flags  <= flags_of(state_n);
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random scoreboard bench for pipe_stage_skid, covering both SKID=1 and SKID=0 builds.
module tb_pipe_stage_skid;

    localparam int unsigned W = 142;
    localparam logic [W-1:0] NOP_A = '0;
    localparam logic [W-1:0] NOP_B = {{(W-16){1'b0}}, 16'hDEAD};

    logic         clk;
    logic         rst;
    logic         flush;
    logic [W-1:0] in_data;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [W-1:0] a_out_data;
    logic [1:0]   a_occ;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [W-1:0] b_out_data;
    logic [1:0]   b_occ;

    logic [W-1:0] q[$];
    int           errors = 0;
    int           checks = 0;

    pipe_stage_skid #(.DATA_W(W), .NOP_VALUE(NOP_A), .SKID(1'b1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_skid #(.DATA_W(W), .NOP_VALUE(NOP_B), .SKID(1'b0)) u_reg (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle on the selected DUT: drive, check against the model, update the model.
    task automatic cyc(input bit sel_b, input logic v, input logic [W-1:0] d,
                       input logic ordy, input logic fl);
        logic         ov, ir, exp_ir;
        logic [W-1:0] od, nop;
        logic [1:0]   oc;
        flush   = fl;
        in_data = d;
        a_in_valid  = sel_b ? 1'b0 : v;
        a_out_ready = sel_b ? 1'b0 : ordy;
        b_in_valid  = sel_b ? v : 1'b0;
        b_out_ready = sel_b ? ordy : 1'b0;
        #1;
        ov  = sel_b ? b_out_valid : a_out_valid;
        ir  = sel_b ? b_in_ready : a_in_ready;
        od  = sel_b ? b_out_data : a_out_data;
        oc  = sel_b ? b_occ : a_occ;
        nop = sel_b ? NOP_B : NOP_A;
        exp_ir = sel_b ? (q.size() == 0 || ordy) : (q.size() < 2);
        check("out_valid", W'(ov), W'(q.size() != 0));
        check("in_ready", W'(ir), W'(exp_ir));
        check("occupancy", W'(oc), W'(q.size()));
        if (!ov)
            check("nop_data", od, nop);
        else if (q.size() != 0)
            check("head_data", od, q[0]);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (v && exp_ir) q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        a_in_valid = 1'b1;
        b_in_valid = 1'b1;
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        in_data = W'(16'h1234);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        #1;
        check("rst_a_valid", W'(a_out_valid), W'(1'b0));
        check("rst_a_data", a_out_data, NOP_A);
        check("rst_a_occ", W'(a_occ), W'(2'd0));
        check("rst_a_ready", W'(a_in_ready), W'(1'b1));
        check("rst_b_valid", W'(b_out_valid), W'(1'b0));
        check("rst_b_data", b_out_data, NOP_B);
        check("rst_b_occ", W'(b_occ), W'(2'd0));
        check("rst_b_ready", W'(b_in_ready), W'(1'b1));
    endtask

    initial begin
        logic [159:0] r;
        do_reset();

        // Streaming on the skid build: 1,2,3,4 back to back, then drain
        for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, W'(i), 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Backpressure: A and B fill both entries, in_valid ignored while full
        cyc(1'b0, 1'b1, W'(8'hA), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, W'(8'hB), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, W'(8'hE), 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Flush with full skid while offering 0xC
        cyc(1'b0, 1'b1, W'(8'h1), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, W'(8'h2), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, W'(8'hC), 1'b0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Simultaneous push and pop while holding one entry
        cyc(1'b0, 1'b1, W'(8'h5), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, W'(8'h6), 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            cyc(1'b0, 1'($urandom_range(0, 1)), r[W-1:0], 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0));
        end

        // SKID=0 build: combinational in_ready follows out_ready
        do_reset();
        cyc(1'b1, 1'b1, W'(8'h7), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, W'(8'h8), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, W'(8'h8), 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, W'(8'h10 + i), 1'b1, 1'b0);
        cyc(1'b1, 1'b1, W'(8'hC), 1'b0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom};
            cyc(1'b1, 1'($urandom_range(0, 1)), r[W-1:0], 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
